mem_responder: RTL

- Memory-side responder for the team's single-strobe memory port, the slave end of the bus driven by the copy and DMA initiators.
- Accepts one read or write command per strobe and holds ready low for a fixed, parameterised latency, plus any extra stall cycles.
- Completes the access against an internal synchronous RAM and returns read data with ready.
- Used as the memory model in block benches and as on-chip scratch memory behind small initiators.

---
 rtl/mem_responder_pkg.sv | 9 +
 rtl/mem_responder_sp_ram.sv | 36 +++
 rtl/mem_responder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and widths for the single-strobe memory port.
package mem_pkg;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   localparam int MEM_AWIDTH = 32;
   localparam int LAT_WIDTH  = 4;

endpackage

// File: rtl/mem_responder_sp_ram.sv
// Single-port synchronous RAM: write enable, registered read, and a
// synchronous clear of the read register so callers can force a zero word.
module sp_ram #(
   parameter int DWIDTH = 12,
   parameter int DEPTH  = 256,
   parameter int AWIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic              i_re,
   input  logic              i_clr,
   input  logic [AWIDTH-1:0] i_addr,
   input  logic [DWIDTH-1:0] i_wdata,
   output logic [DWIDTH-1:0] o_rdata
);

   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic [DWIDTH-1:0] rdata_q;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem_q[i_addr] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_clr) begin
         rdata_q <= '0;
      end else if (i_re) begin
         rdata_q <= mem_q[i_addr];
      end
   end

   assign o_rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Slave end of the single-strobe memory port: one command per strobe,
// ready held low for LATENCY cycles plus stall, access done on completion.
module mem_responder
   import mem_pkg::*;
#(
   parameter int DWIDTH  = 12,
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_strobe,
   input  logic                  i_wrn,
   input  logic [MEM_AWIDTH-1:0] i_addr,
   input  logic [DWIDTH-1:0]     i_wdata,
   input  logic                  i_stall,
   input  logic                  i_err_clr,
   output logic                  o_ready,
   output logic [DWIDTH-1:0]     o_rdata,
   output logic                  o_err_addr,
   output logic                  o_err_proto,
   output state_t                o_dbg_state
);

   localparam int AWIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [LAT_WIDTH-1:0] LAT_INIT = LAT_WIDTH'(LATENCY - 1);

   generate
      if (LATENCY < 1 || LATENCY > 15 || DEPTH < 1) begin : g_bad_param
         $error("mem_responder: LATENCY must be 1..15 and DEPTH >= 1");
      end
   endgenerate

   state_t                state_q, state_d;
   logic [LAT_WIDTH-1:0]  lat_q, lat_d;
   logic                  ready_q, ready_d;
   logic                  wrn_q, wrn_d;
   logic [MEM_AWIDTH-1:0] addr_q, addr_d;
   logic [DWIDTH-1:0]     wdata_q, wdata_d;
   logic                  err_addr_q, err_addr_d;
   logic                  err_proto_q, err_proto_d;
   logic                  complete;
   logic                  in_range;
   logic                  ram_we, ram_re, ram_clr;

   // Address is a signed word index: negative values are out of range.
   assign in_range = !addr_q[MEM_AWIDTH-1] && (addr_q < MEM_AWIDTH'(DEPTH));

   always_comb begin
      state_d  = state_q;
      lat_d    = lat_q;
      ready_d  = ready_q;
      wrn_d    = wrn_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      complete = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_strobe) begin
               wrn_d   = i_wrn;
               addr_d  = i_addr;
               wdata_d = i_wdata;
               ready_d = 1'b0;
               lat_d   = LAT_INIT;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (lat_q != '0) begin
               lat_d = lat_q - 1'b1;
            end else if (!i_stall) begin
               complete = 1'b1;
               ready_d  = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Sticky flags: a set on the same edge as a clear wins.
      err_addr_d  = (complete && !in_range) || (err_addr_q && !i_err_clr);
      err_proto_d = (state_q == S_WAIT && i_strobe) || (err_proto_q && !i_err_clr);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         lat_q       <= '0;
         ready_q     <= 1'b1;
         wrn_q       <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         err_addr_q  <= 1'b0;
         err_proto_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lat_q       <= lat_d;
         ready_q     <= ready_d;
         wrn_q       <= wrn_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         err_addr_q  <= err_addr_d;
         err_proto_q <= err_proto_d;
      end
   end

   // Reset aborts a pending write and zeroes the read register.
   assign ram_we  = complete && wrn_q && in_range && !i_rst;
   assign ram_re  = complete && !wrn_q && in_range;
   assign ram_clr = i_rst || (complete && !wrn_q && !in_range);

   sp_ram #(
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH),
      .AWIDTH (AWIDTH)
   ) u_ram (
      .i_clk   (i_clk),
      .i_we    (ram_we),
      .i_re    (ram_re),
      .i_clr   (ram_clr),
      .i_addr  (addr_q[AWIDTH-1:0]),
      .i_wdata (wdata_q),
      .o_rdata (o_rdata)
   );

   assign o_ready     = ready_q;
   assign o_err_addr  = err_addr_q;
   assign o_err_proto = err_proto_q;
   assign o_dbg_state = state_q;

endmodule
